imem_loader: RTL
================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter INS_ADDRESS, default 9, byte-address width of instruction memory; capacity = 2^(INS_ADDRESS-2) words (128 at default).
REQ-002 Parameter INS_W, default 32, instruction word width; SHALL be 32 (four bytes per word).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle load request; honoured only in IDLE or DONE.
REQ-006 nwords  input  INS_ADDRESS  number of words to load; sampled on accepted start.
REQ-007 in_valid  input  1  byte-stream valid.
REQ-008 in_data  input  8  byte-stream data.
REQ-009 in_ready  output  1  loader accepts a byte this cycle.
REQ-010 waddress  output  32  byte write address to instruction memory, zero-extended.
REQ-011 Datain  output  INS_W  write data to instruction memory.
REQ-012 Wr  output  1  write strobe to instruction memory.
REQ-013 busy  output  1  high in COLLECT or WRITE.
REQ-014 done  output  1  high in DONE.
REQ-015 cpu_hold  output  1  holds processor in reset; low only in DONE.
REQ-016 words_loaded  output  INS_ADDRESS-1  count of words written in current or last load.

Function
REQ-017 States: IDLE, COLLECT, WRITE, DONE; all outputs registered or decoded from state plus registers only.
REQ-018 IDLE/DONE + start, nwords==0: go to DONE; words_loaded=0; no Wr.
REQ-019 IDLE/DONE + start, nwords!=0: latch target=min(nwords, 2^(INS_ADDRESS-2)); clear word and byte counters, words_loaded; go to COLLECT.
REQ-020 start in COLLECT or WRITE SHALL be ignored.
REQ-021 in_ready=1 only in COLLECT; byte transfer = in_valid & in_ready on rising edge.
REQ-022 Assembly little-endian: byte k (k=0..3) of a word into bits [8k+7:8k].
REQ-023 Transfer with byte counter==3: go to WRITE next cycle; byte counter wraps to 0.
REQ-024 in_valid low in COLLECT: hold state, counters, partial word; no timeout.
REQ-025 WRITE lasts exactly one cycle: Wr=1, Datain=assembled word, waddress=word_index*4.
REQ-026 waddress and Datain SHALL be stable for the whole cycle Wr=1 (memory samples on falling edge).
REQ-027 Leaving WRITE: word_index and words_loaded increment; if new words_loaded==target go to DONE, else COLLECT.
REQ-028 Wr=0 and in_ready=0 in every state except WRITE and COLLECT respectively.
REQ-029 Throughput: one word per 5 cycles with in_valid held high (4 COLLECT + 1 WRITE).
REQ-030 nwords above capacity: saturate to capacity; last waddress = (capacity-1)*4; no wrap to address 0.
REQ-031 DONE: done=1, cpu_hold=0, busy=0; held until reset or accepted start.
REQ-032 Restart from DONE: cpu_hold returns to 1 in the cycle after start.

Reset
REQ-033 reset, any state: next state IDLE; in_ready=0, Wr=0, busy=0, done=0, cpu_hold=1, waddress=0, Datain=0, words_loaded=0, counters cleared.
REQ-034 Reset mid-load discards partial word; no Wr issued in or after reset cycle until a new load reaches WRITE.
REQ-035 reset has priority over start and in_valid in the same cycle.

Verification
REQ-036 start, nwords=2, bytes 13,00,00,00,93,00,10,00 continuous -> Wr at cycles 5 and 10 after start; (0x0, 0x00000013), (0x4, 0x00100093); done=1, words_loaded=2, cpu_hold=0.
REQ-037 start, nwords=0 -> DONE next cycle, done=1, no Wr, words_loaded=0.
REQ-038 nwords=1, in_valid toggling 1,0,0,1,0,1,1 with bytes AA,BB,CC,DD -> single Wr, Datain=0xDDCCBBAA, waddress=0.
REQ-039 nwords=200 (INS_ADDRESS=9), 512 bytes -> exactly 128 Wr, last waddress=0x1FC, words_loaded=0 (7-bit wrap of 128) flagged as known; done=1.
REQ-040 reset asserted after 2 bytes of word 1 -> IDLE, cpu_hold=1, Wr never pulsed; new load of 1 word writes address 0 with fresh bytes only.
REQ-041 start pulsed during COLLECT with nwords=5 -> ignored; load completes with original target.

Source files
------------

// File: rtl/imem_loader_if.sv
// Bus bundle between a byte-stream host and the instruction-memory loader.
// The host side (master) issues load requests and streams bytes; the loader
// side (slave) returns the handshake, memory write port and status.
interface imem_loader_if #(
  parameter int INS_ADDRESS = 9,
  parameter int INS_W       = 32
);
  logic                   start;
  logic [INS_ADDRESS-1:0] nwords;
  logic                   in_valid;
  logic [7:0]             in_data;
  logic                   in_ready;
  logic [31:0]            waddress;
  logic [INS_W-1:0]       Datain;
  logic                   Wr;
  logic                   busy;
  logic                   done;
  logic                   cpu_hold;
  logic [INS_ADDRESS-2:0] words_loaded;

  modport master (
    output start, nwords, in_valid, in_data,
    input  in_ready, waddress, Datain, Wr, busy, done, cpu_hold, words_loaded
  );

  modport slave (
    input  start, nwords, in_valid, in_data,
    output in_ready, waddress, Datain, Wr, busy, done, cpu_hold, words_loaded
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a little-endian byte stream into
// 32-bit words and writes them one per WRITE cycle into instruction memory,
// holding the processor in reset until the requested number of words is in.
module imem_loader #(
  parameter int INS_ADDRESS = 9,
  parameter int INS_W       = 32
) (
  input  logic            clk,
  input  logic            reset,
  imem_loader_if.slave    bus
);

  // Word counts need one bit more than a word index so that a full memory
  // (2^(INS_ADDRESS-2) words) is representable as a load target.
  localparam int CNT_W = INS_ADDRESS - 1;
  localparam logic [CNT_W-1:0] CAPACITY = CNT_W'(1) << (INS_ADDRESS - 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_next_s;

  logic [CNT_W-1:0] target_r;
  logic [CNT_W-1:0] loaded_r;
  logic [1:0]       byte_cnt_r;
  logic [23:0]      partial_r;

  logic             in_ready_r;
  logic             wr_r;
  logic             busy_r;
  logic             done_r;
  logic             cpu_hold_r;
  logic [31:0]      waddress_r;
  logic [INS_W-1:0] datain_r;

  logic             xfer_s;
  logic             start_ok_s;
  logic             last_word_s;
  logic [CNT_W-1:0] loaded_inc_s;
  logic [CNT_W-1:0] target_sel_s;

  // A byte moves only while collecting and the source offers one.
  assign xfer_s       = (state_r == COLLECT) & bus.in_valid;
  assign start_ok_s   = ((state_r == IDLE) | (state_r == DONE)) & bus.start;
  assign loaded_inc_s = loaded_r + CNT_ONE;
  assign last_word_s  = (loaded_inc_s == target_r);

  // Saturate the requested word count to the memory capacity.
  always_comb begin
    target_sel_s = CAPACITY;
    if (bus.nwords > INS_ADDRESS'(CAPACITY)) begin
      target_sel_s = CAPACITY;
    end else begin
      target_sel_s = bus.nwords[CNT_W-1:0];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode: start honoured only when idle or done.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (start_ok_s) begin
          if (bus.nwords == {INS_ADDRESS{1'b0}}) begin
            state_next_s = DONE;
          end else begin
            state_next_s = COLLECT;
          end
        end else begin
          state_next_s = state_r;
        end
      end
      COLLECT: begin
        if (xfer_s && (byte_cnt_r == 2'd3)) begin
          state_next_s = WRITE;
        end else begin
          state_next_s = COLLECT;
        end
      end
      WRITE: begin
        if (last_word_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = COLLECT;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Status and strobe outputs, registered from the upcoming state so they
  // line up exactly with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready_r <= 1'b0;
      wr_r       <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      cpu_hold_r <= 1'b1;
    end else begin
      in_ready_r <= (state_next_s == COLLECT);
      wr_r       <= (state_next_s == WRITE);
      busy_r     <= (state_next_s == COLLECT) | (state_next_s == WRITE);
      done_r     <= (state_next_s == DONE);
      cpu_hold_r <= (state_next_s != DONE);
    end
  end

  // Load bookkeeping and word assembly; write address and data are loaded
  // on the edge entering WRITE so they are stable for the whole Wr cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      target_r   <= {CNT_W{1'b0}};
      loaded_r   <= {CNT_W{1'b0}};
      byte_cnt_r <= 2'd0;
      partial_r  <= 24'd0;
      waddress_r <= 32'd0;
      datain_r   <= {INS_W{1'b0}};
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start_ok_s) begin
            loaded_r   <= {CNT_W{1'b0}};
            byte_cnt_r <= 2'd0;
            partial_r  <= 24'd0;
            if (bus.nwords == {INS_ADDRESS{1'b0}}) begin
              target_r <= {CNT_W{1'b0}};
            end else begin
              target_r <= target_sel_s;
            end
          end
        end
        COLLECT: begin
          if (xfer_s) begin
            byte_cnt_r <= byte_cnt_r + 2'd1;
            case (byte_cnt_r)
              2'd0: partial_r[7:0]   <= bus.in_data;
              2'd1: partial_r[15:8]  <= bus.in_data;
              2'd2: partial_r[23:16] <= bus.in_data;
              2'd3: begin
                datain_r   <= INS_W'({bus.in_data, partial_r});
                waddress_r <= 32'({loaded_r, 2'b00});
              end
              default: partial_r <= partial_r;
            endcase
          end
        end
        WRITE: begin
          loaded_r <= loaded_inc_s;
        end
        default: begin
          loaded_r <= loaded_r;
        end
      endcase
    end
  end

  assign bus.in_ready     = in_ready_r;
  assign bus.Wr           = wr_r;
  assign bus.busy         = busy_r;
  assign bus.done         = done_r;
  assign bus.cpu_hold     = cpu_hold_r;
  assign bus.waddress     = waddress_r;
  assign bus.Datain       = datain_r;
  // The reported count wraps at the word-index width: a full-memory load
  // reads back as zero.
  assign bus.words_loaded = {1'b0, loaded_r[INS_ADDRESS-3:0]};

endmodule
